// File: rtl/miner_work_scheduler.sv
// Work scheduler for the sha256 hasher pair: issues nonces, tracks in-flight slots, maps hits to nonces.
// Optional MINER_SCHED_PREEMPT_EN: accept new work in RUN/DRAIN, flushing in-flight slots.
module miner_work_scheduler #(
    parameter int LOOP_LOG2 = 0,
    parameter int LATENCY   = 130
) (
    input  logic         hash_clk,
    input  logic         reset_n,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_data,
    input  logic [31:0]  work_nonce_start,
    input  logic [31:0]  work_nonce_end,
    output logic [255:0] hs_state,
    output logic [127:0] hs_data,
    output logic [5:0]   hs_cnt,
    output logic         hs_feedback,
    input  logic         hit,
    output logic         gn_valid,
    output logic [31:0]  gn_nonce,
    input  logic         gn_ready,
    output logic         gn_overflow,
    output logic         busy,
    output logic         done
);
    // state | meaning
    // IDLE  | no work, waiting for work_valid
    // RUN   | issuing one nonce per LOOP cycles
    // DRAIN | all nonces issued, waiting for in-flight slots to retire
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [5:0] CNT_MASK = 6'((1 << LOOP_LOG2) - 1);

    state_t               state_q, state_d;
    logic [255:0]         midstate_q;
    logic [95:0]          data_q;
    logic [31:0]          nonce_q, end_q, ret_nonce_q;
    logic [5:0]           cnt_q;
    logic [LATENCY-1:0]   tag_q, tag_d;
    logic                 accept, flush, load, tag_out, qual_hit;

`ifdef MINER_SCHED_PREEMPT_EN
    assign work_ready = 1'b1;
`else
    assign work_ready = (state_q == IDLE);
`endif

    assign accept      = work_valid & work_ready;
    assign flush       = accept & (state_q != IDLE);
    assign load        = (state_q == RUN) && (cnt_q == 6'd0);
    assign tag_out     = tag_q[LATENCY-1];
    // a hit arriving in the preempt cycle belongs to discarded work
    assign qual_hit    = hit & tag_out & ~flush;

    assign hs_state    = midstate_q;
    assign hs_data     = {nonce_q, data_q};
    assign hs_cnt      = cnt_q;
    assign hs_feedback = (state_q != IDLE) && (cnt_q != 6'd0);
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        tag_d   = tag_q << 1;
        tag_d[0] = load;
        case (state_q)
            IDLE:  if (accept) state_d = RUN;
            RUN:   if (load && (nonce_q == end_q)) state_d = DRAIN;
            DRAIN: if (tag_q == '0) begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = RUN;
            done    = 1'b0;
            tag_d   = '0;
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            midstate_q  <= '0;
            data_q      <= '0;
            nonce_q     <= '0;
            end_q       <= '0;
            ret_nonce_q <= '0;
            cnt_q       <= '0;
            gn_valid    <= 1'b0;
            gn_nonce    <= '0;
            gn_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            if (accept) begin
                midstate_q  <= work_midstate;
                data_q      <= work_data;
                nonce_q     <= work_nonce_start;
                end_q       <= work_nonce_end;
                ret_nonce_q <= work_nonce_start;
                cnt_q       <= '0;
            end else begin
                if (state_q != IDLE)
                    cnt_q <= (cnt_q + 6'd1) & CNT_MASK;
                if (load && (nonce_q != end_q))
                    nonce_q <= nonce_q + 32'd1;
                if (tag_out)
                    ret_nonce_q <= ret_nonce_q + 32'd1;
            end
            if (qual_hit) begin
                if (!gn_valid || gn_ready) begin
                    gn_valid <= 1'b1;
                    gn_nonce <= ret_nonce_q;
                end else begin
                    gn_overflow <= 1'b1;
                end
            end else if (gn_ready) begin
                gn_valid <= 1'b0;
            end
        end
    end
endmodule
